// File: rtl/road_pkg.sv
// Shared definitions for the road output stage: road-word layout, FSM
// state encoding and the hit-layer popcount helper.
package road_pkg;

  localparam int BX_W        = 8;
  localparam int SECTOR_W    = 6;
  localparam int ROAD_ID_W   = 10;
  localparam int HIT_MASK_W  = 6;

  localparam int HIT_MASK_LSB = 0;
  localparam int ROAD_ID_LSB  = HIT_MASK_LSB + HIT_MASK_W;  // 6
  localparam int SECTOR_LSB   = ROAD_ID_LSB + ROAD_ID_W;    // 16
  localparam int BX_LSB       = SECTOR_LSB + SECTOR_W;      // 22
  localparam int ROAD_WORD_W  = BX_LSB + BX_W;              // 30

  // Field order matches the packed road word, MSB first.
  typedef struct packed {
    logic [BX_W-1:0]       bx;
    logic [SECTOR_W-1:0]   sector;
    logic [ROAD_ID_W-1:0]  road_id;
    logic [HIT_MASK_W-1:0] hit_mask;
  } road_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_EOR   = 2'd3
  } road_state_t;

  // Number of layers with a hit.
  function automatic logic [2:0] popcount(input logic [HIT_MASK_W-1:0] mask);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < HIT_MASK_W; i++) begin
      n = n + {2'b00, mask[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/road_fifo.sv
// Synchronous FIFO with a registered read port. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
module road_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage array write.
  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are live, and a reset here would block RAM inference.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointer update and registered read port; rd_data holds when not reading.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/road_out_buffer.sv
// Per-pipe road output stage: quality filter, stage-1 register, FIFO and
// run-control FSM producing road_data/road_dv and the end-of-run pulse.
// Optional build macro ROAD_OUT_STATS_EN adds saturating road_cnt/drop_cnt.
module road_out_buffer
  import road_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int MIN_HITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sor,
  input  logic                   run_end,
  input  logic                   in_dv,
  input  logic [BX_W-1:0]        in_bx,
  input  logic [SECTOR_W-1:0]    in_sector,
  input  logic [ROAD_ID_W-1:0]   in_road_id,
  input  logic [HIT_MASK_W-1:0]  in_hit_mask,
  input  logic                   hold,
  output logic [ROAD_WORD_W-1:0] road_data,
  output logic                   road_dv,
  output logic                   eor,
  output logic                   ovf,
  output logic                   busy
`ifdef ROAD_OUT_STATS_EN
  ,
  output logic [15:0]            road_cnt,
  output logic [15:0]            drop_cnt
`endif
);

  road_state_t           state_q;
  road_state_t           state_d;
  logic                  start_run;
  logic                  cand_run;
  logic                  qualified;
  logic                  s1_load;
  logic                  s1_valid;
  road_word_t            s1_word;
  logic                  fifo_wr_en;
  logic                  fifo_rd_en;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  ovf_drop;

  assign start_run  = (state_q == ST_IDLE) && sor;
  assign cand_run   = (state_q == ST_RUN) && in_dv;
  assign qualified  = int'(popcount(in_hit_mask)) >= MIN_HITS;
  assign s1_load    = cand_run && qualified;
  // Fullness is the pre-edge value, so a same-cycle read never makes room.
  assign fifo_wr_en = s1_valid && !fifo_full;
  assign ovf_drop   = s1_valid && fifo_full;
  assign fifo_rd_en = !fifo_empty && !hold;

  assign busy = (state_q != ST_IDLE);
  assign eor  = (state_q == ST_EOR);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: drain only finishes once nothing is in flight or on the bus.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (sor) state_d = ST_RUN;
      ST_RUN:   if (run_end) state_d = ST_DRAIN;
      ST_DRAIN: if (!s1_valid && (fifo_count == '0) && !road_dv) state_d = ST_EOR;
      ST_EOR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Stage-1 valid flag: only qualified candidates seen in RUN are captured.
  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= s1_load;
  end

  // Stage-1 payload; meaningful only while s1_valid is set.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_word <= '{bx: in_bx, sector: in_sector, road_id: in_road_id, hit_mask: in_hit_mask};
    end
  end

  // Sticky overflow flag, cleared at the start of each run.
  always_ff @(posedge clk) begin
    if (rst || start_run) ovf <= 1'b0;
    else if (ovf_drop)    ovf <= 1'b1;
  end

  road_fifo #(
    .WIDTH (ROAD_WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fifo_wr_en),
    .wr_data  (s1_word),
    .rd_en    (fifo_rd_en),
    .rd_data  (road_data),
    .rd_valid (road_dv),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

`ifdef ROAD_OUT_STATS_EN
  logic        reject;
  logic [16:0] drop_sum;

  assign reject   = cand_run && !qualified;
  assign drop_sum = {1'b0, drop_cnt} + 17'(reject) + 17'(ovf_drop);

  // Emitted-word counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst || start_run)                  road_cnt <= '0;
    else if (road_dv && road_cnt != 16'hFFFF) road_cnt <= road_cnt + 16'd1;
  end

  // Drop counter; a reject and an overflow can land in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || start_run) drop_cnt <= '0;
    else if (drop_sum[16]) drop_cnt <= 16'hFFFF;
    else                   drop_cnt <= drop_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_road_out_buffer.sv
// Self-checking bench for road_out_buffer: queue-based reference model
// compared every cycle, plus directed sequences for the run-control corners.
module tb_road_out_buffer;

  localparam int DEPTH    = 16;
  localparam int MIN_HITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sor;
  logic        run_end;
  logic        in_dv;
  logic [7:0]  in_bx;
  logic [5:0]  in_sector;
  logic [9:0]  in_road_id;
  logic [5:0]  in_hit_mask;
  logic        hold;
  logic [29:0] road_data;
  logic        road_dv;
  logic        eor;
  logic        ovf;
  logic        busy;
`ifdef ROAD_OUT_STATS_EN
  logic [15:0] road_cnt;
  logic [15:0] drop_cnt;
`endif

  road_out_buffer #(.DEPTH(DEPTH), .MIN_HITS(MIN_HITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .sor         (sor),
    .run_end     (run_end),
    .in_dv       (in_dv),
    .in_bx       (in_bx),
    .in_sector   (in_sector),
    .in_road_id  (in_road_id),
    .in_hit_mask (in_hit_mask),
    .hold        (hold),
    .road_data   (road_data),
    .road_dv     (road_dv),
    .eor         (eor),
    .ovf         (ovf),
    .busy        (busy)
`ifdef ROAD_OUT_STATS_EN
    ,
    .road_cnt    (road_cnt),
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run phase, a one-deep stage, a queue for the FIFO.
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_EOR} mstate_t;
  mstate_t     m_state;
  logic [29:0] mq[$];
  bit          m_s1_valid;
  logic [29:0] m_s1_word;
  bit          m_dv;
  logic [29:0] m_data;
  bit          m_ovf;
  int          m_rc;
  int          m_dc;
  logic [29:0] seen_q[$];

  task automatic model_drop();
    if (m_dc < 65535) m_dc++;
  endtask

  task automatic model_step();
    bit      old_s1;
    bit      old_dv;
    int      old_size;
    bit      full_before;
    bit      qual;
    if (rst) begin
      mq.delete();
      m_s1_valid = 0; m_state = M_IDLE; m_dv = 0; m_data = '0;
      m_ovf = 0; m_rc = 0; m_dc = 0;
      return;
    end
    old_s1 = m_s1_valid; old_dv = m_dv; old_size = mq.size();
    full_before = (old_size >= DEPTH);
    if (old_dv && m_rc < 65535) m_rc++;
    if (old_size > 0 && !hold) begin
      m_data = mq.pop_front();
      m_dv = 1;
    end else begin
      m_dv = 0;
    end
    if (old_s1) begin
      if (!full_before) mq.push_back(m_s1_word);
      else begin m_ovf = 1; model_drop(); end
    end
    qual = ($countones(in_hit_mask) >= MIN_HITS);
    m_s1_valid = (m_state == M_RUN) && in_dv && qual;
    if ((m_state == M_RUN) && in_dv && !qual) model_drop();
    m_s1_word = {in_bx, in_sector, in_road_id, in_hit_mask};
    case (m_state)
      M_IDLE:  if (sor) begin m_state = M_RUN; m_ovf = 0; m_rc = 0; m_dc = 0; end
      M_RUN:   if (run_end) m_state = M_DRAIN;
      M_DRAIN: if (!old_s1 && old_size == 0 && !old_dv) m_state = M_EOR;
      default: m_state = M_IDLE;
    endcase
  endtask

  // One clock: advance the model with the driven inputs, then compare.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (road_dv) seen_q.push_back(road_data);
    check("model_road_dv", road_dv, m_dv);
    check("model_road_data", road_data, m_data);
    check("model_eor", eor, m_state == M_EOR);
    check("model_busy", busy, m_state != M_IDLE);
    check("model_ovf", ovf, m_ovf);
`ifdef ROAD_OUT_STATS_EN
    check("model_road_cnt", road_cnt, m_rc);
    check("model_drop_cnt", drop_cnt, m_dc);
`endif
  endtask

  task automatic set_road(input logic [7:0] bx, input logic [5:0] sec,
                          input logic [9:0] id, input logic [5:0] mask);
    in_dv = 1'b1; in_bx = bx; in_sector = sec; in_road_id = id; in_hit_mask = mask;
  endtask

  task automatic pulse_sor();
    sor = 1'b1; tick(); sor = 1'b0;
  endtask

  task automatic pulse_run_end();
    run_end = 1'b1; tick(); run_end = 1'b0;
  endtask

  // Bounded wait for the end-of-run pulse; a missing pulse counts as a failure.
  task automatic wait_eor();
    int  n = 0;
    bit  done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      tick();
      if (eor) n++;
      check("eor_excl_dv", eor & road_dv, 0);
      if (n > 0 && !busy) done = 1;
    end
    check("eor_pulses", n, 1);
    check("busy_after_eor", busy, 0);
  endtask

  typedef struct {
    logic [5:0] mask;
    bit         kept;
  } mask_vec_t;

  mask_vec_t vecs[8];

  initial begin
    vecs[0] = '{6'h07, 1'b0};
    vecs[1] = '{6'h0F, 1'b1};
    vecs[2] = '{6'h00, 1'b0};
    vecs[3] = '{6'h3F, 1'b1};
    vecs[4] = '{6'h1B, 1'b1};
    vecs[5] = '{6'h31, 1'b0};
    vecs[6] = '{6'h2F, 1'b1};
    vecs[7] = '{6'h01, 1'b0};

    rst = 1'b1; sor = 1'b0; run_end = 1'b0; hold = 1'b0;
    in_dv = 1'b0; in_bx = '0; in_sector = '0; in_road_id = '0; in_hit_mask = '0;

    // Reset state.
    tick(); tick();
    check("rst_road_dv", road_dv, 0);
    check("rst_road_data", road_data, 0);
    check("rst_eor", eor, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    // Single road latency and packing, then end of run.
    pulse_sor();
    check("busy_after_sor", busy, 1);
    set_road(8'h12, 6'd3, 10'h155, 6'h3F);
    tick();
    in_dv = 1'b0;
    check("lat_k", road_dv, 0);
    tick();
    check("lat_k1", road_dv, 0);
    tick();
    check("lat_k2_dv", road_dv, 1);
    check("lat_k2_data", road_data, 30'h0483557F);
    pulse_run_end();
    wait_eor();

    // Quality threshold table.
    pulse_sor();
    for (int i = 0; i < 8; i++) begin
      seen_q.delete();
      set_road(8'(i), 6'd1, 10'(200 + i), vecs[i].mask);
      tick();
      in_dv = 1'b0;
      tick(); tick(); tick();
      check("mask_kept", seen_q.size(), vecs[i].kept ? 1 : 0);
    end
    pulse_run_end();
    wait_eor();

    // Overflow under hold: 16 kept, 4 lost, then drained in order.
    pulse_sor();
    hold = 1'b1;
    seen_q.delete();
    for (int i = 0; i < 20; i++) begin
      set_road(8'h00, 6'd2, 10'(100 + i), 6'h3F);
      tick();
    end
    in_dv = 1'b0;
    tick(); tick(); tick();
    check("ovf_set", ovf, 1);
    check("hold_no_dv", seen_q.size(), 0);
    hold = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    check("ovf_drain_count", seen_q.size(), 16);
    for (int i = 0; i < seen_q.size() && i < 16; i++) begin
      check("ovf_drain_order", seen_q[i][15:6], 100 + i);
    end
    pulse_run_end();
    wait_eor();

    // run_end together with a road; in_dv during DRAIN is ignored.
    pulse_sor();
    check("ovf_cleared_by_sor", ovf, 0);
    seen_q.delete();
    set_road(8'h05, 6'd4, 10'h2AA, 6'h3F);
    run_end = 1'b1;
    tick();
    run_end = 1'b0;
    set_road(8'h06, 6'd4, 10'h111, 6'h3F);
    tick(); tick(); tick();
    in_dv = 1'b0;
    wait_eor();
    check("same_cycle_road_count", seen_q.size(), 1);
    if (seen_q.size() > 0) check("same_cycle_road_id", seen_q[0][15:6], 10'h2AA);

    // Reset in the middle of DRAIN with 5 words queued.
    pulse_sor();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_road(8'h07, 6'd5, 10'(300 + i), 6'h1F);
      tick();
    end
    in_dv = 1'b0;
    tick(); tick();
    pulse_run_end();
    check("drain_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold = 1'b0;
    seen_q.delete();
    begin
      int n_eor = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (eor) n_eor++;
      end
      check("midrst_no_dv", seen_q.size(), 0);
      check("midrst_no_eor", n_eor, 0);
    end
    check("midrst_road_data", road_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ovf", ovf, 0);

    // Randomised run against the reference model.
    pulse_sor();
    for (int i = 0; i < 400; i++) begin
      in_dv       = ($urandom_range(0, 9) < 7);
      in_bx       = 8'($urandom);
      in_sector   = 6'($urandom);
      in_road_id  = 10'($urandom);
      in_hit_mask = 6'($urandom);
      hold        = ($urandom_range(0, 4) == 0);
      tick();
    end
    in_dv = 1'b0;
    hold = 1'b0;
    pulse_run_end();
    wait_eor();

`ifdef ROAD_OUT_STATS_EN
    // Statistics: 10 good roads and 3 rejects, then cleared by sor.
    pulse_sor();
    for (int i = 0; i < 13; i++) begin
      set_road(8'h09, 6'd6, 10'(400 + i), (i % 4 == 3) ? 6'h03 : 6'h3F);
      tick();
    end
    in_dv = 1'b0;
    pulse_run_end();
    wait_eor();
    check("stats_road_cnt", road_cnt, 10);
    check("stats_drop_cnt", drop_cnt, 3);
    pulse_sor();
    check("stats_road_cnt_clr", road_cnt, 0);
    check("stats_drop_cnt_clr", drop_cnt, 0);
    pulse_run_end();
    wait_eor();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
